simon_seq_engine: RTL and testbench
===================================

# simon_seq_engine

Parametrised Simon game controller. It grows a random button sequence one step per round, plays it back to the display/LED layer with timed on/off phases, then checks the player's presses against it. It reports level, loss (wrong press or timeout) and win (full sequence repeated). It sits between the debounced button front-end and the display/sound drivers, clocked by the 60 Hz game tick.

## Interface

**Parameters**
- `NUM_BTN`, 4: number of buttons/colours. `BTN_W = $clog2(NUM_BTN)`, minimum 1.
- `MAX_LEN`, 32: sequence depth. Repeating all `MAX_LEN` steps wins. `LEN_W = $clog2(MAX_LEN+1)`.
- `ON_TICKS`, 30: cycles a step is shown lit during playback.
- `OFF_TICKS`, 15: dark gap after each shown step.
- `TIMEOUT_TICKS`, 300: maximum cycles between player presses.

**Ports**
- `clk`, in, 1: game tick; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: one-cycle pulse; begins a new game from IDLE/OVER/WON; ignored elsewhere.
- `rand_in`, in, BTN_W: free-running random value, sampled in APPEND. Values ≥ NUM_BTN are reduced modulo NUM_BTN.
- `player_valid`, in, 1: one-cycle pulse per debounced press.
- `player_num`, in, BTN_W: button index, qualified by `player_valid`.
- `simon_turn`, out, 1: high in APPEND/PLAY_ON/PLAY_OFF.
- `simon_num`, out, BTN_W: step being shown. Valid while `simon_pressed`; holds last value otherwise.
- `simon_pressed`, out, 1: high only in PLAY_ON.
- `level`, out, LEN_W: current sequence length.
- `game_over`, out, 1: high in OVER.
- `game_won`, out, 1: high in WON.

## Operation

- **Reset:** state IDLE. `level`, `simon_num`, idx, timers = 0. All outputs 0. Sequence memory is not cleared (it is never read beyond `level`).
- **IDLE/OVER/WON + `start`:** `level` ← 0, → APPEND.
- **APPEND:** `mem[level]` ← `rand_in % NUM_BTN`; `level` += 1; idx ← 0; → PLAY_ON.
- **PLAY_ON:** `simon_num` = `mem[idx]`; count the on-time, then → PLAY_OFF.
- **PLAY_OFF:** count `OFF_TICKS`.
  - If idx == level-1: → WAIT_USER, idx ← 0, timeout ← 0.
  - Else: idx += 1, → PLAY_ON.
- **WAIT_USER, `player_valid`:**
  - `player_num` ≠ `mem[idx]`: → OVER.
  - Match and idx < level-1: idx += 1, timeout ← 0.
  - Match and idx == level-1: if `level` == MAX_LEN → WON, else → APPEND.
- **WAIT_USER, no press:** timeout += 1. Reaching TIMEOUT_TICKS → OVER.
- `player_valid` outside WAIT_USER is ignored (no state change).
- `level` holds its final value in OVER/WON for the score display.
- All counters saturate/wrap within width; idx never exceeds MAX_LEN-1.

## Timing

- `start` at edge N → APPEND in cycle N+1 → `simon_pressed` high from edge N+2.
- `simon_pressed` stays high exactly on-time cycles, then low exactly OFF_TICKS cycles per step.
- Playback of level L lasts `L*(on+OFF_TICKS)` cycles.
- Press decision: the state/outputs update on the edge after `player_valid` is sampled (1-cycle latency).
- **Simultaneous `player_valid` and timeout expiry:** the press wins.
- **`reset` mid-game:** immediate return to IDLE; all outputs 0 asynchronously.
- **`start` while busy** (APPEND…WAIT_USER): ignored.

## Configuration

- **`SIMON_SPEEDUP_EN` defined:** on-time = max(ON_TICKS − 2·(level−1), ON_TICKS/4) cycles. OFF_TICKS unchanged.
- **Not defined:** on-time = ON_TICKS for every level.

## Structure

- **Package `simon_pkg`:** state enum (IDLE, APPEND, PLAY_ON, PLAY_OFF, WAIT_USER, OVER, WON) and width helper function.
- **Sub-module `simon_seq_mem`:** MAX_LEN × BTN_W, synchronous write, asynchronous read.
- The FSM, timers and compare logic live in `simon_seq_engine`.

## Test plan

- Reset, then `start` with `rand_in`=2 → `simon_pressed` high 30 cycles with `simon_num`=2, low 15 cycles, then WAIT_USER with `level`=1.
- Level 1 (seq 2): press 2 → APPEND; `rand_in`=1 → playback shows 2 then 1; `level`=2.
- Level 2 (seq 2,1): press 2 then 3 → `game_over`=1 next cycle, `level` stays 2; then `start` → `level` 0→1.
- WAIT_USER with no press for 300 cycles → `game_over`=1. A press at cycle 299 keeps the game alive.
- MAX_LEN=3: answer all rounds correctly → `game_won`=1, `level`=3. With `SIMON_SPEEDUP_EN`, level-3 on-time = 26 cycles.
- Assert `reset` during PLAY_ON → all outputs 0 immediately; `player_valid` during playback → no effect.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon sequence engine.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_WAIT_USER,
    ST_OVER,
    ST_WON
  } simon_state_e;

  // Bit width needed to index 'value' items, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence storage for the Simon engine: one button index per step,
// synchronous write, two asynchronous read ports (playback and player check).
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  localparam int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the newly appended step; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/simon_seq_engine.sv
// Simon game controller: grows a random sequence, plays it back with timed
// on/off phases and checks the player's presses against it.
// Optional macro SIMON_SPEEDUP_EN shortens the lit time as the level grows.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int MAX_LEN       = 32,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 300,
  localparam int BTN_W = clog2_min1(NUM_BTN),
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BTN_W-1:0] rand_in,
  input  logic             player_valid,
  input  logic [BTN_W-1:0] player_num,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LEN_W-1:0] level,
  output logic             game_over,
  output logic             game_won
);

  localparam int IDX_W   = clog2_min1(MAX_LEN);
  localparam int TMR_MAX = (ON_TICKS > OFF_TICKS)
                           ? ((ON_TICKS > TIMEOUT_TICKS) ? ON_TICKS : TIMEOUT_TICKS)
                           : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
  localparam int TMR_W   = clog2_min1(TMR_MAX + 1);
  // Floor of the shrinking lit time; kept at one cycle or more for tiny ON_TICKS.
  localparam int ON_MIN  = (ON_TICKS / 4 < 1) ? 1 : ON_TICKS / 4;

  simon_state_e     state_q, state_d;
  logic [LEN_W-1:0] level_q, level_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BTN_W-1:0] simon_num_q, simon_num_d;
  logic             simon_turn_q, simon_turn_d;
  logic             simon_pressed_q, simon_pressed_d;
  logic             game_over_q, game_over_d;
  logic             game_won_q, game_won_d;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [BTN_W-1:0] mem_wdata;
  logic [BTN_W-1:0] rd_play, rd_check, play_data;
  logic [IDX_W-1:0] last_idx;
  logic [TMR_W-1:0] on_last;

  simon_seq_mem #(
    .DEPTH (MAX_LEN),
    .WIDTH (BTN_W)
  ) u_mem (
    .clk       (clk),
    .wr_en     (mem_we),
    .wr_addr   (mem_waddr),
    .wr_data   (mem_wdata),
    .rd_addr_a (idx_d),
    .rd_data_a (rd_play),
    .rd_addr_b (idx_q),
    .rd_data_b (rd_check)
  );

  // The first shown step of a round may be the one being written this cycle.
  assign play_data = (mem_we && (mem_waddr == idx_d)) ? mem_wdata : rd_play;
  assign last_idx  = IDX_W'(level_q - LEN_W'(1));
  assign mem_wdata = BTN_W'(int'(rand_in) % NUM_BTN);
  assign mem_waddr = IDX_W'(level_q);

`ifdef SIMON_SPEEDUP_EN
  int on_ticks_dyn;

  // Lit time drops by two cycles per level down to a quarter of ON_TICKS.
  always_comb begin
    on_ticks_dyn = ON_TICKS - 2 * (int'(level_q) - 1);
    if (on_ticks_dyn < ON_MIN) on_ticks_dyn = ON_MIN;
  end

  assign on_last = TMR_W'(on_ticks_dyn - 1);
`else
  assign on_last = TMR_W'(ON_TICKS - 1);
`endif

  // Next-state, level, step index and shared timer/timeout counter.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER, ST_WON: begin
        if (start) begin
          level_d = '0;
          state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        mem_we  = 1'b1;
        level_d = level_q + LEN_W'(1);
        idx_d   = '0;
        timer_d = '0;
        state_d = ST_PLAY_ON;
      end
      ST_PLAY_ON: begin
        if (timer_q == on_last) begin
          timer_d = '0;
          state_d = ST_PLAY_OFF;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_PLAY_OFF: begin
        if (timer_q == TMR_W'(OFF_TICKS - 1)) begin
          timer_d = '0;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = ST_WAIT_USER;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_PLAY_ON;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_USER: begin
        // A press in the same cycle as timeout expiry takes priority.
        if (player_valid) begin
          timer_d = '0;
          if (player_num != rd_check) begin
            state_d = ST_OVER;
          end else if (idx_q != last_idx) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (level_q == LEN_W'(MAX_LEN)) begin
            state_d = ST_WON;
          end else begin
            state_d = ST_APPEND;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_TICKS - 1)) begin
          state_d = ST_OVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    simon_num_d     = simon_num_q;
    if (state_d == ST_PLAY_ON) simon_num_d = play_data;
    simon_pressed_d = (state_d == ST_PLAY_ON);
    simon_turn_d    = (state_d == ST_APPEND) || (state_d == ST_PLAY_ON) ||
                      (state_d == ST_PLAY_OFF);
    game_over_d     = (state_d == ST_OVER);
    game_won_d      = (state_d == ST_WON);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      level_q         <= '0;
      idx_q           <= '0;
      timer_q         <= '0;
      simon_num_q     <= '0;
      simon_turn_q    <= 1'b0;
      simon_pressed_q <= 1'b0;
      game_over_q     <= 1'b0;
      game_won_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      idx_q           <= idx_d;
      timer_q         <= timer_d;
      simon_num_q     <= simon_num_d;
      simon_turn_q    <= simon_turn_d;
      simon_pressed_q <= simon_pressed_d;
      game_over_q     <= game_over_d;
      game_won_q      <= game_won_d;
    end
  end

  assign simon_turn    = simon_turn_q;
  assign simon_num     = simon_num_q;
  assign simon_pressed = simon_pressed_q;
  assign level         = level_q;
  assign game_over     = game_over_q;
  assign game_won      = game_won_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Scoreboard bench for simon_seq_engine (NUM_BTN=3, MAX_LEN=3).
module tb_simon_seq_engine;

  localparam int NB   = 3;
  localparam int MAXL = 3;
  localparam int ON   = 30;
  localparam int OFF  = 15;
  localparam int TO   = 300;
  localparam int K_SHOW = 0;
  localparam int K_OVER = 1;
  localparam int K_WON  = 2;

  typedef struct {
    int kind;
    int val;
    int aux;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] rand_in = '0;
  logic       player_valid = 1'b0;
  logic [1:0] player_num = '0;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic [1:0] level;
  logic       game_over;
  logic       game_won;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   c_wait = 0;
  exp_t exp_q[$];
  int   seq[$];

  simon_seq_engine #(
    .NUM_BTN       (NB),
    .MAX_LEN       (MAXL),
    .ON_TICKS      (ON),
    .OFF_TICKS     (OFF),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rand_in       (rand_in),
    .player_valid  (player_valid),
    .player_num    (player_num),
    .simon_turn    (simon_turn),
    .simon_num     (simon_num),
    .simon_pressed (simon_pressed),
    .level         (level),
    .game_over     (game_over),
    .game_won      (game_won)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Lit duration of every step at sequence length len.
  function automatic int on_len(input int len);
    int v;
`ifdef SIMON_SPEEDUP_EN
    v = ON - 2 * (len - 1);
    if (v < ON / 4) v = ON / 4;
`else
    v = ON;
`endif
    return v;
  endfunction

  // Model: extend the sequence and expect the whole of it to be shown.
  task automatic push_round(input int r);
    seq.push_back(r % NB);
    for (int i = 0; i < seq.size(); i++) exp_q.push_back('{K_SHOW, seq[i], on_len(seq.size())});
  endtask

  // Monitor: detects shown steps and game outcomes, pops and compares.
  int   prev_pr = 0, prev_turn = 0, prev_over = 0, prev_won = 0;
  int   hi_len = 0, exp_len = 0, off_cnt = 0;
  bit   in_gap = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_pr = 0; prev_turn = 0; prev_over = 0; prev_won = 0;
      hi_len = 0; in_gap = 0; off_cnt = 0;
    end else begin
      if (simon_pressed && prev_pr == 0) begin
        if (in_gap) begin
          check("off_gap", off_cnt, OFF);
          in_gap = 0;
        end
        if (exp_q.size() == 0) check("show_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("show_kind", K_SHOW, e.kind);
          check("show_num", int'(simon_num), e.val);
          exp_len = e.aux;
        end
        hi_len = 1;
      end else if (simon_pressed) begin
        hi_len++;
      end
      if (!simon_pressed && prev_pr != 0) begin
        check("on_len", hi_len, exp_len);
        in_gap = 1;
        off_cnt = 1;
      end else if (in_gap && !simon_pressed && simon_turn) begin
        off_cnt++;
      end
      if (in_gap && !simon_turn) begin
        check("off_gap", off_cnt, OFF);
        in_gap = 0;
      end
      if (game_over && prev_over == 0) begin
        if (exp_q.size() == 0) check("over_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("over_kind", K_OVER, e.kind);
          check("over_level", int'(level), e.val);
          check("over_cycle", cyc, e.aux);
        end
      end
      if (game_won && prev_won == 0) begin
        if (exp_q.size() == 0) check("won_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("won_kind", K_WON, e.kind);
          check("won_level", int'(level), e.val);
          check("won_cycle", cyc, e.aux);
        end
      end
      prev_pr = int'(simon_pressed);
      prev_turn = int'(simon_turn);
      prev_over = int'(game_over);
      prev_won = int'(game_won);
    end
  end

  task automatic start_game(input int r);
    @(negedge clk);
    seq.delete();
    start = 1'b1;
    rand_in = 2'(r);
    push_round(r);
    @(negedge clk);
    start = 1'b0;
    check("level_after_start", int'(level), 0);
  endtask

  // Wait for playback to finish while injecting ignored presses/starts.
  task automatic wait_user();
    int budget;
    budget = MAXL * (ON + OFF) + 20;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!simon_turn) begin
        player_valid = 1'b0;
        start = 1'b0;
        check("level_at_wait", int'(level), seq.size());
        c_wait = cyc;
        return;
      end
      player_valid = ($urandom_range(0, 7) == 0);
      player_num = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 15) == 0);
      rand_in = 2'($urandom);
    end
    player_valid = 1'b0;
    start = 1'b0;
    check("wait_user_timeout", int'(simon_turn), 0);
  endtask

  task automatic press(input int num, input int gap);
    repeat (gap) @(negedge clk);
    player_valid = 1'b1;
    player_num = 2'(num);
    @(negedge clk);
    player_valid = 1'b0;
  endtask

  // Answer the current round; wrong_at >= 0 presses a wrong button there.
  task automatic play_round(input int wrong_at, input int wrong_val, input int next_r,
                            output bit ended);
    ended = 0;
    for (int i = 0; i < seq.size(); i++) begin
      int g, r, w;
      g = $urandom_range(0, 3);
      if (i == wrong_at) begin
        w = (wrong_val >= 0) ? wrong_val : (seq[i] + 1 + $urandom_range(0, 2)) % 4;
        exp_q.push_back('{K_OVER, seq.size(), cyc + g + 1});
        press(w, g);
        ended = 1;
        return;
      end
      if (i == seq.size() - 1) begin
        if (seq.size() == MAXL) begin
          exp_q.push_back('{K_WON, MAXL, cyc + g + 1});
          press(seq[i], g);
          ended = 1;
          return;
        end
        r = (next_r >= 0) ? next_r : $urandom_range(0, 3);
        rand_in = 2'(r);
        push_round(r);
        press(seq[i], g);
        wait_user();
        return;
      end
      press(seq[i], g);
    end
  endtask

  task automatic run_rounds(input int wrong_level, input int wrong_idx);
    bit ended;
    ended = 0;
    while (!ended) begin
      play_round((seq.size() == wrong_level) ? wrong_idx : -1, -1, -1, ended);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit ended;
    int lvl;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_turn", int'(simon_turn), 0);
    check("rst_pressed", int'(simon_pressed), 0);
    check("rst_num", int'(simon_num), 0);
    check("rst_level", int'(level), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_won", int'(game_won), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Game A: seq 2, then 2,1, then wrong press of 3
    start_game(2);
    wait_user();
    play_round(-1, -1, 1, ended);
    play_round(1, 3, -1, ended);
    repeat (2) @(negedge clk);
    check("over_level_hold", int'(level), 2);
    press(seq[0], 0);
    @(negedge clk);
    check("over_ignores_press", int'(game_over), 1);
    check("over_level_after_press", int'(level), 2);

    // Game B: rand 3 reduces to 0, then timeout
    start_game(3);
    wait_user();
    exp_q.push_back('{K_OVER, 1, c_wait + TO});
    for (int k = 0; k < TO + 20 && !game_over; k++) @(negedge clk);
    check("timeout_over", int'(game_over), 1);

    // Game C: first press at the last timeout cycle, then win
    start_game($urandom_range(0, 3));
    wait_user();
    repeat (TO - 1) @(negedge clk);
    lvl = $urandom_range(0, 3);
    rand_in = 2'(lvl);
    push_round(lvl);
    press(seq[0], 0);
    wait_user();
    run_rounds(-1, 0);
    check("won_flag", int'(game_won), 1);
    check("won_level_hold", int'(level), MAXL);

    // Random games
    for (int g = 0; g < 4; g++) begin
      lvl = $urandom_range(1, MAXL + 1);
      start_game($urandom_range(0, 3));
      wait_user();
      run_rounds(lvl, $urandom_range(0, (lvl > MAXL ? MAXL : lvl) - 1));
    end

    // Reset during playback
    start_game($urandom_range(0, 3));
    for (int k = 0; k < 10 && !simon_pressed; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_pressed", int'(simon_pressed), 1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_turn", int'(simon_turn), 0);
    check("async_rst_pressed", int'(simon_pressed), 0);
    check("async_rst_num", int'(simon_num), 0);
    check("async_rst_level", int'(level), 0);
    check("async_rst_over", int'(game_over), 0);
    check("async_rst_won", int'(game_won), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'(simon_turn), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
